// File: rtl/uio_bus_arbiter.sv
// uio_bus_arbiter: round-robin owner selection and direction control for the
// shared 8-bit uio pad bus. NREQ requesters issue write or read beats; only
// the current owner reaches the pads, and every ownership change or
// write-to-read turnaround passes through a cycle with the pads released.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   ena             design enable; low forces the bus released and idle
//   req, wr, wdata  per-requester request, direction (1=write), write data
//   gnt, busy       registered one-hot ownership and its OR
//   rvalid, rdata   one-cycle read strobe per requester, captured read data
//   uio_in/out/oe   pad input, pad output data, pad output enable
module uio_bus_arbiter #(
    parameter int unsigned NREQ     = 2,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   wr,
    input  logic [8*NREQ-1:0] wdata,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rvalid,
    output logic [7:0]        rdata,
    input  logic [7:0]        uio_in,
    output logic [7:0]        uio_out,
    output logic [7:0]        uio_oe,
    output logic              busy
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned HW = $clog2(MAX_HOLD + 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic [NREQ-1:0]     rvalid_q, rvalid_d;
    logic [7:0]          rdata_q, rdata_d;
    logic [7:0]          uio_out_q, uio_out_d;
    logic [7:0]          uio_oe_q, uio_oe_d;
    logic                busy_q;
    logic [IW-1:0]       last_q, last_d;
    logic [HW-1:0]       hold_q, hold_d;

    logic [IW-1:0]       own_idx;
    logic [IW-1:0]       pick_idx;
    logic                hold_max;
    logic                other_pend;
    logic                leave;

    // First requesting index searching upward from last+1, wrapping
    function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [IW-1:0]   lst);
        logic [IW-1:0] pick;
        logic          found;
        int unsigned   c;
        pick  = lst;
        found = 1'b0;
        for (int i = 1; i <= int'(NREQ); i++) begin
            c = (32'(lst) + 32'(i)) % NREQ;
            if (!found && r[IW'(c)]) begin
                pick  = IW'(c);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Index of the set bit of a one-hot vector (0 when empty)
    function automatic logic [IW-1:0] oh_index(input logic [NREQ-1:0] g);
        logic [IW-1:0] idx;
        idx = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (g[i]) idx = IW'(i);
        end
        return idx;
    endfunction

    assign own_idx    = oh_index(gnt_q);
    assign pick_idx   = rr_pick(req, last_q);
    assign hold_max   = (hold_q == HW'(MAX_HOLD));
    assign other_pend = |(req & ~gnt_q);
    // Departure uses the registered count, so a beat that lands on MAX_HOLD
    // still completes and the yield happens on the following cycle.
    assign leave      = !req[own_idx] || (hold_max && other_pend);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            rvalid_q  <= '0;
            rdata_q   <= 8'h00;
            uio_out_q <= 8'h00;
            uio_oe_q  <= 8'h00;
            busy_q    <= 1'b0;
            last_q    <= IW'(NREQ - 1);
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            uio_out_q <= uio_out_d;
            uio_oe_q  <= uio_oe_d;
            busy_q    <= |gnt_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (ena && |req)      state_d = OWN;
            OWN:  if (!ena || leave)    state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and bookkeeping
    always_comb begin
        gnt_d     = gnt_q;
        rvalid_d  = '0;
        rdata_d   = rdata_q;
        uio_out_d = uio_out_q;
        uio_oe_d  = uio_oe_q;
        last_d    = last_q;
        hold_d    = hold_q;
        case (state_q)
            IDLE: begin
                gnt_d    = '0;
                uio_oe_d = 8'h00;
                if (ena && |req) begin
                    gnt_d  = NREQ'(1) << pick_idx;
                    last_d = pick_idx;
                    hold_d = '0;
                end
            end
            OWN: begin
                if (!ena || leave) begin
                    gnt_d    = '0;
                    uio_oe_d = 8'h00;
                end else if (wr[own_idx]) begin
                    uio_out_d = wdata[{own_idx, 3'b000} +: 8];
                    uio_oe_d  = 8'hFF;
                    hold_d    = hold_max ? hold_q : hold_q + HW'(1);
                end else if (uio_oe_q != 8'h00) begin
                    // Read behind a write: release the pads for one cycle first
                    uio_oe_d = 8'h00;
                end else begin
                    rdata_d           = uio_in;
                    rvalid_d[own_idx] = 1'b1;
                    hold_d            = hold_max ? hold_q : hold_q + HW'(1);
                end
            end
            default: begin
                gnt_d    = '0;
                uio_oe_d = 8'h00;
            end
        endcase
    end

    assign gnt     = gnt_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign uio_out = uio_out_q;
    assign uio_oe  = uio_oe_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Directed bench for uio_bus_arbiter (NREQ=2, MAX_HOLD=8): a vector table of
// per-cycle inputs and expected registered outputs, plus looped sequences for
// fairness rotation and uncontended back-to-back writes.
module tb_uio_bus_arbiter;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic [1:0]  req;
    logic [1:0]  wr;
    logic [15:0] wdata;
    logic [1:0]  gnt;
    logic [1:0]  rvalid;
    logic [7:0]  rdata;
    logic [7:0]  uio_in;
    logic [7:0]  uio_out;
    logic [7:0]  uio_oe;
    logic        busy;

    int n_cmp;
    int n_fail;

    uio_bus_arbiter #(.NREQ(2), .MAX_HOLD(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .req     (req),
        .wr      (wr),
        .wdata   (wdata),
        .gnt     (gnt),
        .rvalid  (rvalid),
        .rdata   (rdata),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       ena;
        logic [1:0] req;
        logic [1:0] wr;
        logic [7:0] wd0;
        logic [7:0] wd1;
        logic [7:0] uin;
        logic [1:0] e_gnt;
        logic [1:0] e_rv;
        logic [7:0] e_rdata;
        logic [7:0] e_out;
        logic [7:0] e_oe;
        logic       e_busy;
    } vec_t;

    vec_t vecs[23];

    function automatic vec_t mk(input logic r, input logic e, input logic [1:0] q,
                                input logic [1:0] w, input logic [7:0] d0,
                                input logic [7:0] d1, input logic [7:0] ui,
                                input logic [1:0] g, input logic [1:0] rv,
                                input logic [7:0] rd, input logic [7:0] uo,
                                input logic [7:0] oe, input logic b);
        vec_t v;
        v.rst_n = r;  v.ena = e;  v.req = q;  v.wr = w;
        v.wd0 = d0;   v.wd1 = d1; v.uin = ui;
        v.e_gnt = g;  v.e_rv = rv; v.e_rdata = rd;
        v.e_out = uo; v.e_oe = oe; v.e_busy = b;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic [1:0] q,
                         input logic [1:0] w, input logic [7:0] d0,
                         input logic [7:0] d1, input logic [7:0] ui);
        rst_n  = r;
        ena    = e;
        req    = q;
        wr     = w;
        wdata  = {d1, d0};
        uio_in = ui;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        ena    = 1'b1;
        req    = 2'b00;
        wr     = 2'b00;
        wdata  = 16'h0000;
        uio_in = 8'h00;

        //              rst ena req    wr     wd0    wd1    uin      gnt    rv     rdata  out    oe     busy
        // reset arbitration
        vecs[0]  = mk(1'b0, 1'b1, 2'b11, 2'b11, 8'h11, 8'h22, 8'h00,  2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 1'b0);
        vecs[1]  = mk(1'b0, 1'b1, 2'b11, 2'b11, 8'h11, 8'h22, 8'h00,  2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 1'b0);
        vecs[2]  = mk(1'b1, 1'b1, 2'b11, 2'b11, 8'h11, 8'h22, 8'h00,  2'b01, 2'b00, 8'h00, 8'h00, 8'h00, 1'b1);
        vecs[3]  = mk(1'b1, 1'b1, 2'b00, 2'b11, 8'h11, 8'h22, 8'h00,  2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 1'b0);
        vecs[4]  = mk(1'b1, 1'b1, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00,  2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 1'b0);
        // single write from requester 0
        vecs[5]  = mk(1'b1, 1'b1, 2'b01, 2'b01, 8'hA5, 8'h00, 8'h00,  2'b01, 2'b00, 8'h00, 8'h00, 8'h00, 1'b1);
        vecs[6]  = mk(1'b1, 1'b1, 2'b01, 2'b01, 8'hA5, 8'h00, 8'h00,  2'b01, 2'b00, 8'h00, 8'hA5, 8'hFF, 1'b1);
        vecs[7]  = mk(1'b1, 1'b1, 2'b00, 2'b01, 8'hA5, 8'h00, 8'h00,  2'b00, 2'b00, 8'h00, 8'hA5, 8'h00, 1'b0);
        // owner 1: write, stalled read, read, write
        vecs[8]  = mk(1'b1, 1'b1, 2'b10, 2'b10, 8'h00, 8'h3C, 8'h00,  2'b10, 2'b00, 8'h00, 8'hA5, 8'h00, 1'b1);
        vecs[9]  = mk(1'b1, 1'b1, 2'b10, 2'b10, 8'h00, 8'h3C, 8'h00,  2'b10, 2'b00, 8'h00, 8'h3C, 8'hFF, 1'b1);
        vecs[10] = mk(1'b1, 1'b1, 2'b10, 2'b00, 8'h00, 8'h3C, 8'h5A,  2'b10, 2'b00, 8'h00, 8'h3C, 8'h00, 1'b1);
        vecs[11] = mk(1'b1, 1'b1, 2'b10, 2'b00, 8'h00, 8'h3C, 8'h5A,  2'b10, 2'b10, 8'h5A, 8'h3C, 8'h00, 1'b1);
        vecs[12] = mk(1'b1, 1'b1, 2'b10, 2'b10, 8'h00, 8'h77, 8'h00,  2'b10, 2'b00, 8'h5A, 8'h77, 8'hFF, 1'b1);
        // reset while owner 1 drives the pads
        vecs[13] = mk(1'b0, 1'b1, 2'b11, 2'b11, 8'hC1, 8'hD2, 8'h00,  2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 1'b0);
        vecs[14] = mk(1'b1, 1'b1, 2'b11, 2'b11, 8'hC1, 8'hD2, 8'h00,  2'b01, 2'b00, 8'h00, 8'h00, 8'h00, 1'b1);
        vecs[15] = mk(1'b1, 1'b1, 2'b11, 2'b11, 8'hC1, 8'hD2, 8'h00,  2'b01, 2'b00, 8'h00, 8'hC1, 8'hFF, 1'b1);
        vecs[16] = mk(1'b1, 1'b1, 2'b10, 2'b10, 8'hC1, 8'hD2, 8'h00,  2'b00, 2'b00, 8'h00, 8'hC1, 8'h00, 1'b0);
        vecs[17] = mk(1'b1, 1'b1, 2'b10, 2'b10, 8'hC1, 8'hD2, 8'h00,  2'b10, 2'b00, 8'h00, 8'hC1, 8'h00, 1'b1);
        vecs[18] = mk(1'b1, 1'b1, 2'b10, 2'b10, 8'hC1, 8'hD2, 8'h00,  2'b10, 2'b00, 8'h00, 8'hD2, 8'hFF, 1'b1);
        // ena low while owner 1 drives; arbitration resumes after last=1
        vecs[19] = mk(1'b1, 1'b0, 2'b11, 2'b11, 8'hE1, 8'hE2, 8'h00,  2'b00, 2'b00, 8'h00, 8'hD2, 8'h00, 1'b0);
        vecs[20] = mk(1'b1, 1'b0, 2'b11, 2'b11, 8'hE1, 8'hE2, 8'h00,  2'b00, 2'b00, 8'h00, 8'hD2, 8'h00, 1'b0);
        vecs[21] = mk(1'b1, 1'b1, 2'b11, 2'b11, 8'hE1, 8'hE2, 8'h00,  2'b01, 2'b00, 8'h00, 8'hD2, 8'h00, 1'b1);
        vecs[22] = mk(1'b1, 1'b1, 2'b00, 2'b00, 8'hE1, 8'hE2, 8'h00,  2'b00, 2'b00, 8'h00, 8'hD2, 8'h00, 1'b0);

        for (int i = 0; i < 23; i++) begin
            drive(vecs[i].rst_n, vecs[i].ena, vecs[i].req, vecs[i].wr,
                  vecs[i].wd0, vecs[i].wd1, vecs[i].uin);
            check($sformatf("v%0d.gnt", i),    16'(gnt),     16'(vecs[i].e_gnt));
            check($sformatf("v%0d.rvalid", i), 16'(rvalid),  16'(vecs[i].e_rv));
            check($sformatf("v%0d.rdata", i),  16'(rdata),   16'(vecs[i].e_rdata));
            check($sformatf("v%0d.uio_out", i),16'(uio_out), 16'(vecs[i].e_out));
            check($sformatf("v%0d.uio_oe", i), 16'(uio_oe),  16'(vecs[i].e_oe));
            check($sformatf("v%0d.busy", i),   16'(busy),    16'(vecs[i].e_busy));
        end

        // Fairness: both write continuously. Per owner, 10 edges:
        // grant, 8 accepted writes, yield to IDLE. Owner 0 first after reset.
        drive(1'b0, 1'b1, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00);
        check("fair.reset_gnt", 16'(gnt), 16'h0000);
        for (int e = 0; e < 40; e++) begin
            int p;
            int own;
            logic [1:0] exp_g;
            drive(1'b1, 1'b1, 2'b11, 2'b11, 8'hAA, 8'hBB, 8'h00);
            p     = e % 10;
            own   = (e / 10) % 2;
            exp_g = (own == 0) ? 2'b01 : 2'b10;
            if (p == 9) begin
                check($sformatf("fair%0d.gnt", e), 16'(gnt),    16'h0000);
                check($sformatf("fair%0d.oe", e),  16'(uio_oe), 16'h0000);
            end else if (p == 0) begin
                check($sformatf("fair%0d.gnt", e), 16'(gnt),    16'(exp_g));
                check($sformatf("fair%0d.oe", e),  16'(uio_oe), 16'h0000);
            end else begin
                check($sformatf("fair%0d.gnt", e), 16'(gnt),    16'(exp_g));
                check($sformatf("fair%0d.oe", e),  16'(uio_oe), 16'h00FF);
                check($sformatf("fair%0d.out", e), 16'(uio_out),
                      (own == 0) ? 16'h00AA : 16'h00BB);
            end
        end

        // No contention: 20 back-to-back writes, hold count saturates silently
        drive(1'b0, 1'b1, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00);
        drive(1'b1, 1'b1, 2'b01, 2'b01, 8'h00, 8'h00, 8'h00);
        check("solo.grant", 16'(gnt), 16'h0001);
        for (int n = 1; n <= 20; n++) begin
            logic [7:0] d;
            d = 8'(n * 7 + 1);
            drive(1'b1, 1'b1, 2'b01, 2'b01, d, 8'h00, 8'h00);
            check($sformatf("solo%0d.gnt", n), 16'(gnt),     16'h0001);
            check($sformatf("solo%0d.oe", n),  16'(uio_oe),  16'h00FF);
            check($sformatf("solo%0d.out", n), 16'(uio_out), 16'(d));
            check($sformatf("solo%0d.rv", n),  16'(rvalid),  16'h0000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uio_bus_arbiter.md
Name: uio_bus_arbiter

Overview:
Round-robin arbiter and direction controller for the 8-bit bidirectional uio pad bus of tt_um_WillyJules_chipbootcamp. It shares the uio pins among NREQ internal requesters, each of which issues write or read beats. It drives uio_out/uio_oe and captures uio_in. It guarantees that only one requester owns the bus at a time and inserts a bus-release cycle on every ownership change or write-to-read turnaround.

Parameters:
NREQ, 2, number of requesters (2..4).
MAX_HOLD, 8, accepted beats an owner may complete before it must yield to another pending requester.

Ports:
clk  in  1  system clock.
rst_n  in  1  synchronous active-low reset.
ena  in  1  design enable; low forces a release.
req  in  NREQ  per-requester bus request; held high while the requester wants beats.
wr  in  NREQ  beat direction of requester k: 1 = write, 0 = read.
wdata  in  8*NREQ  write data; requester k uses bits [8k+7:8k].
gnt  out  NREQ  registered ownership, one-hot or zero.
rvalid  out  NREQ  one-cycle pulse, read data valid for requester k.
rdata  out  8  captured read data.
uio_in  in  8  pad input.
uio_out  out  8  pad output data.
uio_oe  out  8  pad output enable (8'hFF or 8'h00 only).
busy  out  1  equals |gnt.

Behaviour:
- One clock: clk. Reset is synchronous and active-low: rst_n. All outputs are registered.
- Reset (rst_n=0 at an edge): gnt=0, rvalid=0, rdata=0, uio_out=0, uio_oe=0, busy=0, state=IDLE, hold_cnt=0, last=NREQ-1, so requester 0 wins first. Reset overrides everything, including mid-transfer.
- hold_cnt width is clog2(MAX_HOLD+1). It saturates at MAX_HOLD.
- State IDLE: gnt=0, uio_oe=0.
  - If any req is high, the winner w is the first requester with req high, searching from last+1 modulo NREQ.
  - Next edge: gnt[w]=1, last=w, hold_cnt=0, state=OWN.
  - No beat is ever accepted in IDLE.
- State OWN, owner k:
  - A beat is accepted in a cycle when gnt[k] & req[k] & ena, unless it is a stalled read (below).
  - Accepted write: next edge uio_out=wdata[k], uio_oe=8'hFF, hold_cnt+1.
  - Accepted read: next edge rdata=uio_in sampled at that edge, rvalid[k]=1 for one cycle, hold_cnt+1.
  - Stalled read: a read request while uio_oe=8'hFF is not accepted. Next edge uio_oe=8'h00; the read is accepted in the following cycle. The turnaround is exactly 1 cycle.
  - With no accepted beat, uio_out and uio_oe hold their values.
- Leaving OWN: the next edge goes to IDLE with gnt=0 and uio_oe=8'h00 when either
  - req[k]=0, or
  - hold_cnt==MAX_HOLD and any other req is high.
  - If hold_cnt==MAX_HOLD and no other requester is pending, the owner keeps the bus and beats continue.
  - uio_out retains its last value; uio_oe is 0.
- Ownership change: always passes through at least one IDLE cycle with uio_oe=0, so there is never a drive-drive overlap.
- Simultaneous leave and beat: if the owner's final cycle has req[k]=1 and a beat is accepted while hold_cnt reaches MAX_HOLD, that beat completes. The departure is then evaluated on the following cycle.
- ena=0 at an edge:
  - state=IDLE, gnt=0, uio_oe=0, rvalid=0.
  - rdata, uio_out and last hold their values.
  - No beats are accepted while ena=0.
- rvalid is never asserted for a non-owner. gnt and rvalid are at most one-hot.

Test Plan:
1. Reset arbitration: rst_n=0 for 2 cycles with req=2'b11 -> all outputs 0. First edge after release: gnt=2'b01, busy=1.
2. Single write: req0=1, wr0=1, wdata0=8'hA5 -> gnt=01 one cycle after req. The cycle after that: uio_out=A5, uio_oe=FF. Drop req0 -> next edge gnt=00, uio_oe=00.
3. Write-then-read turnaround: owner 1 writes 8'h3C, then wr1=0 with uio_in=8'h5A -> one stall cycle with uio_oe=00 and no rvalid. Then rvalid=2'b10 for one cycle with rdata=5A.
4. Fairness: both requesters continuously writing, MAX_HOLD=8 -> owner 0 completes exactly 8 writes, then 1 IDLE cycle with uio_oe=00, then gnt=10 for 8 writes. The pattern alternates indefinitely.
5. No contention: only req0 high for 20 write beats -> gnt stays 01 and all 20 beats are accepted back-to-back.
6. Mid-operation reset and ena: while owner 1 is driving FF, pull rst_n low -> next edge gnt=0, uio_oe=0; with req=11 after release, requester 0 wins. Repeat with ena=0 -> IDLE with uio_oe=0. On ena=1, arbitration resumes from last+1.
